// File: rtl/branch_sched.sv
// ---------------------------------------------------------------------------
// branch_sched
//   Resolves the branch-class ops of one VLIW bundle. An accepted bundle has
//   its pending slots evaluated one per cycle, lowest index first, through a
//   single shared comparator. The first taken slot raises a redirect that
//   squashes younger pending slots. Jumps with rd != 0 emit a link writeback.
//
// Parameters
//   NUM_SLOTS  number of issue slots that may carry a branch-class op
//   TRAP_VEC   redirect target for ecall/ebreak
//
// Ports
//   clk, rst_n                          clock, async active-low reset
//   bundle_valid / bundle_ready         bundle handshake (ready only in IDLE)
//   bundle_pc                           PC of slot 0 (slot i at +4*i)
//   slot_req                            per-slot branch-class op present
//   slot_op, slot_is_jmp,
//   slot_is_imm_type, slot_zero_ext     decoded control per slot
//   slot_imm, slot_rd,
//   slot_rs1_val, slot_rs2_val          decoded fields and operands per slot
//   redirect_valid / redirect_ready,
//   redirect_target, squash_mask        redirect handshake
//   link_valid, link_rd, link_data      link writeback for JAL/JALR
//   sched_done                          one-cycle pulse, bundle resolved
//   stat_eval_cnt, stat_taken_cnt       saturating counters, present only
//                                       when BRANCH_SCHED_STATS_EN is defined
// ---------------------------------------------------------------------------
module branch_sched #(
    parameter int unsigned NUM_SLOTS = 4,
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      bundle_valid,
    output logic                      bundle_ready,
    input  logic [31:0]               bundle_pc,
    input  logic [NUM_SLOTS-1:0]      slot_req,
    input  logic [2*NUM_SLOTS-1:0]    slot_op,
    input  logic [NUM_SLOTS-1:0]      slot_is_jmp,
    input  logic [NUM_SLOTS-1:0]      slot_is_imm_type,
    input  logic [NUM_SLOTS-1:0]      slot_zero_ext,
    input  logic [20*NUM_SLOTS-1:0]   slot_imm,
    input  logic [5*NUM_SLOTS-1:0]    slot_rd,
    input  logic [32*NUM_SLOTS-1:0]   slot_rs1_val,
    input  logic [32*NUM_SLOTS-1:0]   slot_rs2_val,
    output logic                      redirect_valid,
    input  logic                      redirect_ready,
    output logic [31:0]               redirect_target,
    output logic [NUM_SLOTS-1:0]      squash_mask,
    output logic                      link_valid,
    output logic [4:0]                link_rd,
    output logic [31:0]               link_data,
    output logic                      sched_done
`ifdef BRANCH_SCHED_STATS_EN
    ,
    output logic [31:0]               stat_eval_cnt,
    output logic [31:0]               stat_taken_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EVAL,
        S_REDIRECT
    } state_e;

    state_e state_q, state_d;

    // Bundle registers captured on accept
    logic [31:0]             pc_q;
    logic [NUM_SLOTS-1:0]    pend_q, pend_d;
    logic [2*NUM_SLOTS-1:0]  op_q;
    logic [NUM_SLOTS-1:0]    jmp_q, immt_q, zext_q;
    logic [20*NUM_SLOTS-1:0] imm_q;
    logic [5*NUM_SLOTS-1:0]  rd_q;
    logic [32*NUM_SLOTS-1:0] rs1_q, rs2_q;

    // Redirect registers
    logic [31:0]             target_q, target_d;
    logic [NUM_SLOTS-1:0]    squash_q, squash_d;

    // Selected slot (lowest-index pending) and its fields
    logic                    found;
    logic [31:0]             s_idx;
    logic [1:0]              s_op;
    logic                    s_jmp, s_immt, s_zext;
    logic [19:0]             s_imm;
    logic [4:0]              s_rd;
    logic [31:0]             s_rs1, s_rs2;
    logic [31:0]             s_pc;
    logic [NUM_SLOTS-1:0]    pend_clr;
    logic [NUM_SLOTS-1:0]    younger;

    // Evaluation results
    logic                    cmp_eq, cmp_lt, cmp_res;
    logic                    taken, is_link;
    logic [31:0]             tgt;
    logic [31:0]             br_tgt, jal_tgt, jalr_tgt;
    logic                    accept;
    logic                    evaluating;

    assign accept     = (state_q == S_IDLE) && bundle_valid;
    assign evaluating = (state_q == S_EVAL) && found;

    // Slot selection: priority pick of the lowest pending index. The same
    // loop extracts that slot's fields and builds the post-clear mask and
    // the mask of pending slots younger than the selected one.
    always_comb begin
        found    = 1'b0;
        s_idx    = '0;
        s_op     = '0;
        s_jmp    = 1'b0;
        s_immt   = 1'b0;
        s_zext   = 1'b0;
        s_imm    = '0;
        s_rd     = '0;
        s_rs1    = '0;
        s_rs2    = '0;
        pend_clr = pend_q;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (!found && pend_q[i]) begin
                found       = 1'b1;
                s_idx       = 32'(i);
                s_op        = op_q[i*2 +: 2];
                s_jmp       = jmp_q[i];
                s_immt      = immt_q[i];
                s_zext      = zext_q[i];
                s_imm       = imm_q[i*20 +: 20];
                s_rd        = rd_q[i*5 +: 5];
                s_rs1       = rs1_q[i*32 +: 32];
                s_rs2       = rs2_q[i*32 +: 32];
                pend_clr[i] = 1'b0;
            end
        end
        younger = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            younger[i] = pend_q[i] && (32'(i) > s_idx);
        end
        s_pc = pc_q + (s_idx << 2);
    end

    // Shared comparator and target adders
    always_comb begin
        cmp_eq   = (s_rs1 == s_rs2);
        cmp_lt   = s_zext ? (s_rs1 < s_rs2) : ($signed(s_rs1) < $signed(s_rs2));
        unique case (s_op)
            2'b00:   cmp_res = cmp_eq;
            2'b01:   cmp_res = !cmp_eq;
            2'b10:   cmp_res = cmp_lt;
            default: cmp_res = !cmp_lt;
        endcase

        br_tgt   = s_pc + {{19{s_imm[11]}}, s_imm[11:0], 1'b0};
        jal_tgt  = s_pc + {{11{s_imm[19]}}, s_imm, 1'b0};
        jalr_tgt = (s_rs1 + {{20{s_imm[11]}}, s_imm[11:0]}) & ~32'h1;

        taken   = 1'b0;
        is_link = 1'b0;
        tgt     = br_tgt;
        if (s_jmp) begin
            if (s_immt) begin
                taken   = 1'b1;
                is_link = 1'b1;
                tgt     = jalr_tgt;
            end else begin
                // Non-immediate jump encodings 10/11 are undefined; they
                // fall through like a not-taken branch.
                unique case (s_op)
                    2'b00: begin
                        taken   = 1'b1;
                        is_link = 1'b1;
                        tgt     = jal_tgt;
                    end
                    2'b01: begin
                        taken = 1'b1;
                        tgt   = TRAP_VEC;
                    end
                    default: taken = 1'b0;
                endcase
            end
        end else begin
            taken = cmp_res;
        end
    end

    // Next state and outputs
    always_comb begin
        state_d        = state_q;
        pend_d         = pend_q;
        target_d       = target_q;
        squash_d       = squash_q;
        bundle_ready   = (state_q == S_IDLE);
        redirect_valid = 1'b0;
        redirect_target = '0;
        squash_mask    = '0;
        link_valid     = 1'b0;
        link_rd        = '0;
        link_data      = '0;
        sched_done     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bundle_valid) begin
                    pend_d  = slot_req;
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                if (!found) begin
                    // Empty bundle: resolved with a single EVAL cycle
                    sched_done = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    if (is_link && (s_rd != 5'd0)) begin
                        link_valid = 1'b1;
                        link_rd    = s_rd;
                        link_data  = s_pc + 32'd4;
                    end
                    if (taken) begin
                        target_d = tgt;
                        squash_d = younger;
                        pend_d   = '0;
                        state_d  = S_REDIRECT;
                    end else begin
                        pend_d = pend_clr;
                        if (pend_clr == '0) begin
                            sched_done = 1'b1;
                            state_d    = S_IDLE;
                        end
                    end
                end
            end
            S_REDIRECT: begin
                redirect_valid  = 1'b1;
                redirect_target = target_q;
                squash_mask     = squash_q;
                if (redirect_ready) begin
                    sched_done = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pend_q   <= '0;
            target_q <= '0;
            squash_q <= '0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            target_q <= target_d;
            squash_q <= squash_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= '0;
            op_q   <= '0;
            jmp_q  <= '0;
            immt_q <= '0;
            zext_q <= '0;
            imm_q  <= '0;
            rd_q   <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
        end else if (accept) begin
            pc_q   <= bundle_pc;
            op_q   <= slot_op;
            jmp_q  <= slot_is_jmp;
            immt_q <= slot_is_imm_type;
            zext_q <= slot_zero_ext;
            imm_q  <= slot_imm;
            rd_q   <= slot_rd;
            rs1_q  <= slot_rs1_val;
            rs2_q  <= slot_rs2_val;
        end
    end

`ifdef BRANCH_SCHED_STATS_EN
    logic [31:0] eval_cnt_q, taken_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eval_cnt_q  <= '0;
            taken_cnt_q <= '0;
        end else begin
            if (evaluating && (eval_cnt_q != '1)) begin
                eval_cnt_q <= eval_cnt_q + 32'd1;
            end
            if (evaluating && taken && (taken_cnt_q != '1)) begin
                taken_cnt_q <= taken_cnt_q + 32'd1;
            end
        end
    end

    assign stat_eval_cnt  = eval_cnt_q;
    assign stat_taken_cnt = taken_cnt_q;
`else
    logic unused_eval;
    assign unused_eval = evaluating;
`endif

endmodule
